// File: rtl/flt2int_sched.sv
// Round-robin scheduler that shares one flt2int core among NREQ requesters.
// Moves each operand through the core's data memory and returns the result on a response bus.
module flt2int_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned A_OPHI  = 4,
    parameter int unsigned A_RESHI = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      rq_valid,
    input  logic [16*NREQ-1:0]   rq_data,
    output logic [NREQ-1:0]      rq_ready,
    output logic                 resp_valid,
    output logic [2:0]           resp_id,
    output logic [15:0]          resp_data,
    output logic                 resp_err,
    output logic                 dm_we,
    output logic [7:0]           dm_addr,
    output logic [7:0]           dm_wdata,
    input  logic [7:0]           dm_rdata,
    output logic                 core_req,
    input  logic                 core_ack,
    output logic                 busy,
    output logic [7:0]           jobs_done
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWrHi  = 3'd1;
    localparam logic [2:0] StWrLo  = 3'd2;
    localparam logic [2:0] StStart = 3'd3;
    localparam logic [2:0] StWait  = 3'd4;
    localparam logic [2:0] StRdHi  = 3'd5;
    localparam logic [2:0] StRdLo  = 3'd6;
    localparam logic [2:0] StResp  = 3'd7;

    logic [2:0]   state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   id_q, id_d;
    logic [15:0]  op_q, op_d;
    logic         err_q, err_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [7:0]   res_hi_q, res_hi_d;
    logic [2:0]   resp_id_q, resp_id_d;
    logic [15:0]  resp_data_q, resp_data_d;
    logic         resp_err_q, resp_err_d;
    logic [7:0]   jobs_q, jobs_d;

    logic [7:0]   valid_pad;
    logic [127:0] data_pad;
    logic [3:0]   cand;
    logic [3:0]   ptr_nxt;
    logic         gnt_found;
    logic [2:0]   gnt_idx;
    logic [15:0]  resp_now;

    // Cyclic search for the first valid request at or after the pointer.
    always_comb begin
        valid_pad = 8'(rq_valid);
        data_pad  = 128'(rq_data);
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        cand      = 4'd0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (!gnt_found && valid_pad[cand[2:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[2:0];
            end
        end
        ptr_nxt = {1'b0, gnt_idx} + 4'd1;
    end

    assign resp_now = err_q ? 16'h0000 : {res_hi_q, dm_rdata};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        res_hi_d    = res_hi_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        jobs_d      = jobs_q;
        rq_ready    = '0;
        dm_we       = 1'b0;
        dm_addr     = 8'd0;
        dm_wdata    = 8'd0;
        core_req    = 1'b0;
        case (state_q)
            StIdle: begin
                // Grant is masked while reset is held so rq_ready stays low.
                if (gnt_found && !reset) begin
                    rq_ready = NREQ'(1) << gnt_idx;
                    id_d     = gnt_idx;
                    op_d     = data_pad[{gnt_idx, 4'b0000} +: 16];
                    err_d    = 1'b0;
                    ptr_d    = (ptr_nxt == 4'(NREQ)) ? 3'd0 : ptr_nxt[2:0];
                    state_d  = StWrHi;
                end
            end
            StWrHi: begin
                dm_we    = 1'b1;
                dm_addr  = 8'(A_OPHI);
                dm_wdata = op_q[15:8];
                state_d  = StWrLo;
            end
            StWrLo: begin
                dm_we    = 1'b1;
                dm_addr  = 8'(A_OPHI + 1);
                dm_wdata = op_q[7:0];
                state_d  = StStart;
            end
            StStart: begin
                core_req = 1'b1;
                cnt_d    = 16'd0;
                state_d  = StWait;
            end
            StWait: begin
                if (core_ack) begin
                    state_d = StRdHi;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StRdHi: begin
                dm_addr = 8'(A_RESHI);
                state_d = StRdLo;
            end
            StRdLo: begin
                dm_addr  = 8'(A_RESHI + 1);
                res_hi_d = dm_rdata;
                state_d  = StResp;
            end
            StResp: begin
                resp_id_d   = id_q;
                resp_err_d  = err_q;
                resp_data_d = resp_now;
                jobs_d      = jobs_q + 8'd1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= 3'd0;
            id_q        <= 3'd0;
            op_q        <= 16'd0;
            err_q       <= 1'b0;
            cnt_q       <= 16'd0;
            res_hi_q    <= 8'd0;
            resp_id_q   <= 3'd0;
            resp_data_q <= 16'd0;
            resp_err_q  <= 1'b0;
            jobs_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            res_hi_q    <= res_hi_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            jobs_q      <= jobs_d;
        end
    end

    // The low result byte arrives during RESP itself, so the live value bypasses the hold regs.
    assign resp_valid = (state_q == StResp);
    assign resp_id    = resp_valid ? id_q : resp_id_q;
    assign resp_data  = resp_valid ? resp_now : resp_data_q;
    assign resp_err   = resp_valid ? err_q : resp_err_q;
    assign busy       = (state_q != StIdle);
    assign jobs_done  = jobs_q;

endmodule

// File: tb/tb_flt2int_sched.sv
// Self-checking bench for flt2int_sched: memory/core model, vector table, hand sequences and
// randomized round-robin traffic against a queue-based reference model.
module tb_flt2int_sched;

    localparam int N  = 3;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   rq_valid;
    logic [16*N-1:0] rq_data;
    logic [N-1:0]   rq_ready;
    logic           resp_valid;
    logic [2:0]     resp_id;
    logic [15:0]    resp_data;
    logic           resp_err;
    logic           dm_we;
    logic [7:0]     dm_addr;
    logic [7:0]     dm_wdata;
    logic [7:0]     dm_rdata;
    logic           core_req;
    logic           core_ack;
    logic           busy;
    logic [7:0]     jobs_done;

    flt2int_sched #(
        .NREQ    (N),
        .TIMEOUT (TO),
        .A_OPHI  (4),
        .A_RESHI (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rq_valid   (rq_valid),
        .rq_data    (rq_data),
        .rq_ready   (rq_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .core_req   (core_req),
        .core_ack   (core_ack),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Half-precision to integer, truncating toward zero.
    function automatic logic [15:0] conv(input logic [15:0] h);
        int e, m, mag;
        e = int'(h[14:10]);
        m = 1024 + int'(h[9:0]);
        if (e < 15) mag = 0;
        else if (e >= 25) mag = m << (e - 25);
        else mag = m >> (25 - e);
        if (h[15]) mag = -mag;
        return mag[15:0];
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] h;
        h[15]    = 1'($urandom_range(0, 1));
        h[14:10] = 5'($urandom_range(10, 29));
        h[9:0]   = 10'($urandom_range(0, 1023));
        return h;
    endfunction

    // Memory and core model
    logic [7:0]  mem [256];
    logic        ack_hit = 1'b0;
    logic        spur = 1'b0;
    int          env_dly = 2;
    bit          env_never = 1'b0;
    bit          env_rnd = 1'b0;
    int          pend = 0;
    bit          armed = 1'b0;
    logic [15:0] core_res;
    int          n_creq = 0;
    int          creq_cyc = 0;
    int          n_rd = 0;
    logic [15:0] wr_log [$];
    logic [7:0]  rd_next;

    assign core_ack = ack_hit | spur;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        dm_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                armed = 1'b0;
                pend  = 0;
            end else begin
                if (dm_we) begin
                    mem[dm_addr] = dm_wdata;
                    wr_log.push_back({dm_addr, dm_wdata});
                end
                if (!dm_we && (dm_addr == 8'd6 || dm_addr == 8'd7)) n_rd++;
                if (core_req) begin
                    n_creq++;
                    creq_cyc = cyc;
                    core_res = conv({mem[4], mem[5]});
                    mem[6]   = 8'hEE;
                    mem[7]   = 8'hEE;
                    armed    = !env_never;
                    pend     = env_rnd ? int'($urandom_range(1, 4)) : env_dly;
                end
            end
            rd_next = mem[dm_addr];
            @(posedge clk);
            #1;
            dm_rdata = rd_next;
            ack_hit  = 1'b0;
            if (armed && !reset) begin
                pend--;
                if (pend == 0) begin
                    ack_hit = 1'b1;
                    mem[6]  = core_res[15:8];
                    mem[7]  = core_res[7:0];
                    armed   = 1'b0;
                end
            end
        end
    end

    // Reference model state
    int mptr  = 0;
    int mjobs = 0;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] data;
    } exp_t;
    exp_t        q [$];
    int          order [$];
    logic [15:0] sop [N];
    int          rem [N];
    bit          act [N];

    typedef struct {
        int          id;
        logic [15:0] op;
        int          dly;
        bit          never;
        bit          sp;
        logic [15:0] exp_data;
        bit          exp_err;
    } vec_t;
    vec_t tbl [7];

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        rq_valid = '0;
        spur     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mptr  = 0;
        mjobs = 0;
    endtask

    task automatic run_job(input int id, input logic [15:0] op, input int dly, input bit never,
                           input bit sp, input logic [15:0] exp_data, input bit exp_err,
                           input string nm);
        int g, r, lat;
        bit got;
        env_dly   = dly;
        env_never = never;
        env_rnd   = 1'b0;
        n_creq    = 0;
        n_rd      = 0;
        wr_log.delete();
        @(posedge clk);
        #1;
        rq_valid[id]         = 1'b1;
        rq_data[16*id +: 16] = op;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (rq_ready != '0) got = 1'b1;
        end
        chk({nm, " grant"}, 32'(rq_ready), 32'(1) << id);
        g    = cyc;
        mptr = (id + 1) % N;
        @(posedge clk);
        #1;
        rq_valid[id] = 1'b0;
        @(posedge clk);
        #1;
        spur = sp;
        @(posedge clk);
        #1;
        spur = 1'b0;
        got = 1'b0;
        for (int t = 0; t < TO + 30 && !got; t++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        chk({nm, " resp seen"}, 32'(got), 32'd1);
        r   = cyc;
        lat = (never || dly > TO) ? 4 + TO : 6 + dly;
        chk({nm, " core_req latency"}, 32'(creq_cyc - g), 32'd3);
        chk({nm, " core_req pulses"}, 32'(n_creq), 32'd1);
        chk({nm, " resp latency"}, 32'(r - g), 32'(lat));
        chk({nm, " resp_id"}, 32'(resp_id), 32'(id));
        chk({nm, " resp_data"}, 32'(resp_data), 32'(exp_data));
        chk({nm, " resp_err"}, 32'(resp_err), 32'(exp_err));
        chk({nm, " mem reads"}, 32'(n_rd), exp_err ? 32'd0 : 32'd2);
        chk({nm, " write count"}, 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            chk({nm, " write hi"}, 32'(wr_log[0]), {16'd0, 8'd4, op[15:8]});
            chk({nm, " write lo"}, 32'(wr_log[1]), {16'd0, 8'd5, op[7:0]});
        end
        mjobs++;
        @(negedge clk);
        chk({nm, " jobs_done"}, 32'(jobs_done), 32'(mjobs % 256));
        chk({nm, " idle after"}, 32'(busy), 32'd0);
        chk({nm, " resp_data held"}, 32'(resp_data), 32'(exp_data));
    endtask

    task automatic run_traffic(input int target, input bit rnd, input string nm);
        int grants, nresp, budget, gj;
        logic [N-1:0] er;
        exp_t e;
        grants    = 0;
        nresp     = 0;
        budget    = target * 25 + 50;
        env_rnd   = 1'b1;
        env_never = 1'b0;
        q.delete();
        order.delete();
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        for (int c = 0; c < budget && nresp < target; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (grants >= target) begin
                    act[i] = 1'b0;
                end else if (!act[i] && rem[i] > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
                    act[i] = 1'b1;
                    rem[i]--;
                    if (rnd) sop[i] = rand_op();
                end
                rq_valid[i]         = act[i];
                rq_data[16*i +: 16] = sop[i];
            end
            @(negedge clk);
            er = '0;
            gj = 0;
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    if (act[(mptr + k) % N] && er == '0) begin
                        gj = (mptr + k) % N;
                        er = N'(1) << gj;
                    end
                end
            end
            if (er != '0 || rq_ready != '0) chk({nm, " rr grant"}, 32'(rq_ready), 32'(er));
            if (er != '0) begin
                q.push_back({3'(gj), conv(sop[gj])});
                order.push_back(gj);
                mptr = (gj + 1) % N;
                act[gj] = 1'b0;
                grants++;
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk({nm, " unexpected resp"}, 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk({nm, " resp_id"}, 32'(resp_id), 32'(e.id));
                    chk({nm, " resp_data"}, 32'(resp_data), 32'(e.data));
                    chk({nm, " resp_err"}, 32'(resp_err), 32'd0);
                end
                nresp++;
                mjobs++;
            end
        end
        chk({nm, " responses"}, 32'(nresp), 32'(target));
        @(negedge clk);
        chk({nm, " jobs_done"}, 32'(jobs_done), 32'(mjobs % 256));
        rq_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        reset    = 1'b1;
        rq_valid = '0;
        rq_data  = '0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rq_ready", 32'(rq_ready), 32'd0);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_data", 32'(resp_data), 32'd0);
        chk("reset resp_id", 32'(resp_id), 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset dm_we", 32'(dm_we), 32'd0);
        chk("reset dm_addr", 32'(dm_addr), 32'd0);
        chk("reset core_req", 32'(core_req), 32'd0);
        chk("reset jobs_done", 32'(jobs_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Spurious ack while idle
        @(posedge clk);
        #1;
        spur = 1'b1;
        @(negedge clk);
        chk("spur idle busy", 32'(busy), 32'd0);
        chk("spur idle core_req", 32'(core_req), 32'd0);
        @(posedge clk);
        #1;
        spur = 1'b0;

        tbl[0] = '{0, 16'h3C00, 2, 1'b0, 1'b0, 16'h0001, 1'b0};
        tbl[1] = '{1, 16'h4000, 1, 1'b0, 1'b0, 16'h0002, 1'b0};
        tbl[2] = '{2, 16'hC500, 3, 1'b0, 1'b1, 16'hFFFB, 1'b0};
        tbl[3] = '{0, 16'h5A40, TO, 1'b0, 1'b0, 16'h00C8, 1'b0};
        tbl[4] = '{1, 16'h4600, TO + 1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{2, 16'h3800, 2, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[6] = '{0, 16'hBC00, 2, 1'b0, 1'b0, 16'hFFFF, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].id, tbl[i].op, tbl[i].dly, tbl[i].never, tbl[i].sp,
                    tbl[i].exp_data, tbl[i].exp_err, $sformatf("vec%0d", i));
        end

        // Contention: two rounds of req0 + req1 held together
        do_reset();
        sop[0] = 16'h4000; sop[1] = 16'h4600; sop[2] = 16'h0000;
        rem[0] = 2; rem[1] = 2; rem[2] = 0;
        run_traffic(4, 1'b0, "contend");
        chk("contend order size", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            chk("contend order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]},
                32'h00010001);
        end

        // Reset while waiting for the core
        env_never = 1'b1;
        env_rnd   = 1'b0;
        @(posedge clk);
        #1;
        rq_valid[0]    = 1'b1;
        rq_data[15:0]  = 16'h4000;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (rq_ready[0]) got = 1'b1;
        end
        chk("rstwait grant", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        rq_valid[0] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (core_req) got = 1'b1;
        end
        chk("rstwait core_req", 32'(got), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rq_valid[1] = 1'b1;
        reset = 1'b1;
        #1;
        chk("rstwait busy", 32'(busy), 32'd0);
        chk("rstwait dm_we", 32'(dm_we), 32'd0);
        chk("rstwait core_req", 32'(core_req), 32'd0);
        chk("rstwait rq_ready", 32'(rq_ready), 32'd0);
        chk("rstwait jobs_done", 32'(jobs_done), 32'd0);
        @(negedge clk);
        chk("rstwait resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        rq_valid = '0;
        reset    = 1'b0;
        mptr     = 0;
        mjobs    = 0;
        run_job(1, 16'h4600, 2, 1'b0, 1'b0, 16'h0006, 1'b0, "post-reset");

        // Randomized traffic
        for (int i = 0; i < N; i++) rem[i] = 60;
        run_traffic(150, 1'b1, "random");

        // 256 back-to-back jobs wrap jobs_done
        do_reset();
        sop[0] = 16'h3C00; sop[1] = 16'h4000; sop[2] = 16'hC500;
        for (int i = 0; i < N; i++) rem[i] = 1000;
        run_traffic(256, 1'b0, "wrap");
        chk("wrap jobs_done zero", 32'(jobs_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
